// File: rtl/cache_pkg.sv
// Shared bus-command, MSI-state and write-entry encodings for the two-core cache system.
package cache_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'b00,
        BUS_RD     = 2'b01,
        BUS_WR     = 2'b10,
        BUS_UPDATE = 2'b11
    } bus_cmd_e;

    typedef enum logic [1:0] {
        INVALID  = 2'b00,
        SHARED   = 2'b01,
        MODIFIED = 2'b10
    } msi_state_e;

    localparam int unsigned WE_ADDR_BITS = 6;
    localparam int unsigned WE_DATA_BITS = 8;

    typedef struct packed {
        logic [WE_ADDR_BITS-1:0] addr;
        logic [WE_DATA_BITS-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/hub_fifo.sv
// Parameterised FIFO (push/pop/full/empty) that also exposes its contents oldest-first,
// with per-entry valid bits, so the hub can search pending writes for forwarding.
module hub_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH*WIDTH-1:0] entries,
    output logic [DEPTH-1:0]       valid
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    int unsigned      slot;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (32'(count) == DEPTH);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        entries = '0;
        valid   = '0;
        slot    = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = 32'(rd_ptr) + i;
            if (slot >= DEPTH) begin
                slot = slot - DEPTH;
            end
            entries[i*WIDTH +: WIDTH] = mem[PW'(slot)];
            valid[i]                  = (i < 32'(count));
        end
    end

endmodule

// File: rtl/coherence_bus_hub.sv
// Shared-bus hub for the two-core MSI system: round-robin snoop broadcast plus main memory
// behind per-core write buffers. Define BUS_PERF_EN to add grant/conflict counters.
module coherence_bus_hub
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 11,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned MEM_ADDR_BITS = 6,
    parameter int unsigned BUSQ_DEPTH    = 2,
    parameter int unsigned WBUF_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               c0_bus_cmd,
    input  logic [ADDR_BITS-1:0]     c0_bus_addr,
    input  logic [DATA_BITS-1:0]     c0_bus_data,
    input  logic [1:0]               c1_bus_cmd,
    input  logic [ADDR_BITS-1:0]     c1_bus_addr,
    input  logic [DATA_BITS-1:0]     c1_bus_data,
    output logic [1:0]               snp_bus_cmd,
    output logic [ADDR_BITS-1:0]     snp_bus_addr,
    output logic [DATA_BITS-1:0]     snp_bus_data,
    output logic                     snp_src_id,
    input  logic                     c0_mem_rd_en,
    input  logic [MEM_ADDR_BITS-1:0] c0_mem_rd_addr,
    output logic [DATA_BITS-1:0]     c0_mem_rd_data,
    input  logic                     c0_mem_wr_en,
    input  logic [MEM_ADDR_BITS-1:0] c0_mem_wr_addr,
    input  logic [DATA_BITS-1:0]     c0_mem_wr_data,
    input  logic                     c1_mem_rd_en,
    input  logic [MEM_ADDR_BITS-1:0] c1_mem_rd_addr,
    output logic [DATA_BITS-1:0]     c1_mem_rd_data,
    input  logic                     c1_mem_wr_en,
    input  logic [MEM_ADDR_BITS-1:0] c1_mem_wr_addr,
    input  logic [DATA_BITS-1:0]     c1_mem_wr_data,
    output logic [1:0]               bus_ovf,
    output logic [1:0]               wbuf_ovf
`ifdef BUS_PERF_EN
    ,
    output logic [15:0]              perf_txn,
    output logic [15:0]              perf_conflict
`endif
);
    localparam int unsigned BW        = 2 + ADDR_BITS + DATA_BITS;
    localparam int unsigned WW        = MEM_ADDR_BITS + DATA_BITS;
    localparam int unsigned MEM_WORDS = 2 ** MEM_ADDR_BITS;

    logic [BW-1:0]            live_req [2];
    logic [WW-1:0]            wr_req   [2];
    logic [MEM_ADDR_BITS-1:0] rd_addr  [2];
    logic [1:0]               live, rd_en, wr_en;

    logic [BW-1:0]              bq_head [2];
    logic [BUSQ_DEPTH*BW-1:0]   bq_ent  [2];
    logic [BUSQ_DEPTH-1:0]      bq_vld  [2];
    logic [1:0]                 bq_full, bq_empty, bq_push, bq_pop, bq_drop;
    logic [WW-1:0]              wb_head [2];
    logic [WBUF_DEPTH*WW-1:0]   wb_ent  [2];
    logic [WBUF_DEPTH-1:0]      wb_vld  [2];
    logic [1:0]                 wb_full, wb_empty, wb_pop, wb_drop;

    logic [1:0]          cand, gnt_oh, wcand;
    logic [BW-1:0]       cand_val [2];
    logic [BW-1:0]       gnt_val;
    logic                gnt_any, gnt_id, rr_ptr;
    logic                dr_any, dr_id, wr_rr;
    logic [WW-1:0]       dr_head;
    logic [DATA_BITS:0]  own_hit [2];
    logic [DATA_BITS:0]  oth_hit [2];
    logic [DATA_BITS-1:0] rd_next [2];
    logic [DATA_BITS-1:0] mem [MEM_WORDS];
    logic                unused_bq;

    assign live_req[0] = {c0_bus_cmd, c0_bus_addr, c0_bus_data};
    assign live_req[1] = {c1_bus_cmd, c1_bus_addr, c1_bus_data};
    assign wr_req[0]   = {c0_mem_wr_addr, c0_mem_wr_data};
    assign wr_req[1]   = {c1_mem_wr_addr, c1_mem_wr_data};
    assign rd_addr[0]  = c0_mem_rd_addr;
    assign rd_addr[1]  = c1_mem_rd_addr;
    assign live        = {c1_bus_cmd != BUS_IDLE, c0_bus_cmd != BUS_IDLE};
    assign rd_en       = {c1_mem_rd_en, c0_mem_rd_en};
    assign wr_en       = {c1_mem_wr_en, c0_mem_wr_en};
    assign unused_bq   = ^{bq_ent[0], bq_ent[1], bq_vld[0], bq_vld[1]};

    for (genvar n = 0; n < 2; n++) begin : g_core
        hub_fifo #(.WIDTH(BW), .DEPTH(BUSQ_DEPTH)) u_busq (
            .clk(clk), .rst(rst), .push(bq_push[n]), .push_data(live_req[n]), .pop(bq_pop[n]),
            .head(bq_head[n]), .full(bq_full[n]), .empty(bq_empty[n]),
            .entries(bq_ent[n]), .valid(bq_vld[n])
        );
        hub_fifo #(.WIDTH(WW), .DEPTH(WBUF_DEPTH)) u_wbuf (
            .clk(clk), .rst(rst), .push(wr_en[n]), .push_data(wr_req[n]), .pop(wb_pop[n]),
            .head(wb_head[n]), .full(wb_full[n]), .empty(wb_empty[n]),
            .entries(wb_ent[n]), .valid(wb_vld[n])
        );
    end

    // A queued request always outranks its core's live input; the live one queues behind it.
    assign cand        = ~bq_empty | live;
    assign cand_val[0] = bq_empty[0] ? live_req[0] : bq_head[0];
    assign cand_val[1] = bq_empty[1] ? live_req[1] : bq_head[1];
    assign gnt_any     = |cand;
    assign gnt_id      = (&cand) ? rr_ptr : cand[1];
    assign gnt_oh      = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign gnt_val     = gnt_id ? cand_val[1] : cand_val[0];
    assign bq_pop      = gnt_oh & ~bq_empty;
    assign bq_push     = live & ~(gnt_oh & bq_empty);
    assign bq_drop     = bq_push & bq_full & ~bq_pop;

    assign wcand   = ~wb_empty;
    assign dr_any  = |wcand;
    assign dr_id   = (&wcand) ? wr_rr : wcand[1];
    assign wb_pop  = dr_any ? (dr_id ? 2'b10 : 2'b01) : 2'b00;
    assign dr_head = dr_id ? wb_head[1] : wb_head[0];
    assign wb_drop = wr_en & wb_full & ~wb_pop;

    function automatic logic [DATA_BITS:0] newest_match(
        input logic [WBUF_DEPTH*WW-1:0]  ent,
        input logic [WBUF_DEPTH-1:0]     vld,
        input logic [MEM_ADDR_BITS-1:0]  addr
    );
        logic [DATA_BITS:0] r;
        r = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            if (vld[i] && ent[i*WW + DATA_BITS +: MEM_ADDR_BITS] == addr) begin
                r = {1'b1, ent[i*WW +: DATA_BITS]};
            end
        end
        return r;
    endfunction

    // Reads see only state registered before this edge, so same-cycle writes are invisible.
    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            own_hit[n] = newest_match(wb_ent[n], wb_vld[n], rd_addr[n]);
            oth_hit[n] = newest_match(wb_ent[1-n], wb_vld[1-n], rd_addr[n]);
            if (own_hit[n][DATA_BITS]) begin
                rd_next[n] = own_hit[n][DATA_BITS-1:0];
            end else if (oth_hit[n][DATA_BITS]) begin
                rd_next[n] = oth_hit[n][DATA_BITS-1:0];
            end else begin
                rd_next[n] = mem[rd_addr[n]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snp_bus_cmd    <= '0;
            snp_bus_addr   <= '0;
            snp_bus_data   <= '0;
            snp_src_id     <= 1'b0;
            rr_ptr         <= 1'b0;
            wr_rr          <= 1'b0;
            bus_ovf        <= '0;
            wbuf_ovf       <= '0;
            c0_mem_rd_data <= '0;
            c1_mem_rd_data <= '0;
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem[MEM_ADDR_BITS'(i)] <= '0;
            end
        end else begin
            if (gnt_any) begin
                {snp_bus_cmd, snp_bus_addr, snp_bus_data} <= gnt_val;
                snp_src_id <= gnt_id;
                rr_ptr     <= ~gnt_id;
            end else begin
                snp_bus_cmd  <= '0;
                snp_bus_addr <= '0;
                snp_bus_data <= '0;
                snp_src_id   <= 1'b0;
            end
            if (dr_any) begin
                mem[dr_head[WW-1:DATA_BITS]] <= dr_head[DATA_BITS-1:0];
                wr_rr <= ~dr_id;
            end
            bus_ovf  <= bus_ovf | bq_drop;
            wbuf_ovf <= wbuf_ovf | wb_drop;
            if (rd_en[0]) begin
                c0_mem_rd_data <= rd_next[0];
            end
            if (rd_en[1]) begin
                c1_mem_rd_data <= rd_next[1];
            end
        end
    end

`ifdef BUS_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_txn      <= '0;
            perf_conflict <= '0;
        end else begin
            if (gnt_any && perf_txn != '1) begin
                perf_txn <= perf_txn + 1'b1;
            end
            if ((&cand) && perf_conflict != '1) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coherence_bus_hub.sv
// Randomised and directed checks of coherence_bus_hub against a queue-based reference model.
module tb_coherence_bus_hub;
    localparam int AB = 11;
    localparam int DB = 8;
    localparam int MB = 6;
    localparam int QD = 2;
    localparam int WD = 4;

    typedef logic [AB+DB+1:0] breq_t;
    typedef logic [MB+DB-1:0] went_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cmd     [2];
    logic [AB-1:0] addr    [2];
    logic [DB-1:0] data    [2];
    logic          rd_en   [2];
    logic [MB-1:0] rd_addr [2];
    logic [DB-1:0] rd_data [2];
    logic          wr_en   [2];
    logic [MB-1:0] wr_addr [2];
    logic [DB-1:0] wr_data [2];
    logic [1:0]    snp_cmd;
    logic [AB-1:0] snp_addr;
    logic [DB-1:0] snp_data;
    logic          snp_src;
    logic [1:0]    bus_ovf, wbuf_ovf;

    breq_t         mq [2][$];
    went_t         mw [2][$];
    logic [DB-1:0] mmem [64];
    logic          mrr, mwrr;
    breq_t         exp_snp;
    logic          exp_src;
    logic [DB-1:0] exp_rd [2];
    logic [1:0]    exp_bovf, exp_wovf;
    int            vectors = 0;
    int            errors  = 0;

    always #5 clk = ~clk;

    coherence_bus_hub #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .MEM_ADDR_BITS(MB), .BUSQ_DEPTH(QD), .WBUF_DEPTH(WD)
    ) dut (
        .clk(clk), .rst(rst),
        .c0_bus_cmd(cmd[0]), .c0_bus_addr(addr[0]), .c0_bus_data(data[0]),
        .c1_bus_cmd(cmd[1]), .c1_bus_addr(addr[1]), .c1_bus_data(data[1]),
        .snp_bus_cmd(snp_cmd), .snp_bus_addr(snp_addr), .snp_bus_data(snp_data), .snp_src_id(snp_src),
        .c0_mem_rd_en(rd_en[0]), .c0_mem_rd_addr(rd_addr[0]), .c0_mem_rd_data(rd_data[0]),
        .c0_mem_wr_en(wr_en[0]), .c0_mem_wr_addr(wr_addr[0]), .c0_mem_wr_data(wr_data[0]),
        .c1_mem_rd_en(rd_en[1]), .c1_mem_rd_addr(rd_addr[1]), .c1_mem_rd_data(rd_data[1]),
        .c1_mem_wr_en(wr_en[1]), .c1_mem_wr_addr(wr_addr[1]), .c1_mem_wr_data(wr_data[1]),
        .bus_ovf(bus_ovf), .wbuf_ovf(wbuf_ovf)
    );

    // Value a core would read now: its own newest pending write, then the other core's, then memory.
    function automatic logic [DB-1:0] lookup(int n, logic [MB-1:0] a);
        went_t e;
        for (int k = mw[n].size() - 1; k >= 0; k--) begin
            e = mw[n][k];
            if (e[MB+DB-1:DB] == a) return e[DB-1:0];
        end
        for (int k = mw[1-n].size() - 1; k >= 0; k--) begin
            e = mw[1-n][k];
            if (e[MB+DB-1:DB] == a) return e[DB-1:0];
        end
        return mmem[a];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            mq[n].delete();
            mw[n].delete();
            exp_rd[n] = '0;
        end
        for (int i = 0; i < 64; i++) mmem[i] = '0;
        mrr = 1'b0; mwrr = 1'b0;
        exp_snp = '0; exp_src = 1'b0;
        exp_bovf = '0; exp_wovf = '0;
    endtask

    task automatic model_update();
        breq_t live [2];
        breq_t cv   [2];
        logic  lv   [2];
        logic  has  [2];
        logic  served;
        went_t e;
        int    g, wg;
        for (int n = 0; n < 2; n++) begin
            if (rd_en[n]) exp_rd[n] = lookup(n, rd_addr[n]);
        end
        for (int n = 0; n < 2; n++) begin
            live[n] = {cmd[n], addr[n], data[n]};
            lv[n]   = (cmd[n] != 2'b00);
            has[n]  = (mq[n].size() > 0) || lv[n];
            cv[n]   = (mq[n].size() > 0) ? mq[n][0] : live[n];
        end
        g = -1;
        if (has[0] && has[1]) g = int'(mrr);
        else if (has[0])      g = 0;
        else if (has[1])      g = 1;
        if (g >= 0) begin
            exp_snp = cv[g];
            exp_src = (g == 1);
            mrr     = (g == 0);
        end else begin
            exp_snp = '0;
            exp_src = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            served = 1'b0;
            if (g == n) begin
                if (mq[n].size() > 0) void'(mq[n].pop_front());
                else served = 1'b1;
            end
            if (lv[n] && !served) begin
                if (mq[n].size() < QD) mq[n].push_back(live[n]);
                else exp_bovf[n] = 1'b1;
            end
        end
        wg = -1;
        if (mw[0].size() > 0 && mw[1].size() > 0) wg = int'(mwrr);
        else if (mw[0].size() > 0)                wg = 0;
        else if (mw[1].size() > 0)                wg = 1;
        if (wg >= 0) begin
            e = mw[wg].pop_front();
            mmem[e[MB+DB-1:DB]] = e[DB-1:0];
            mwrr = (wg == 0);
        end
        for (int n = 0; n < 2; n++) begin
            if (wr_en[n]) begin
                if (mw[n].size() < WD) mw[n].push_back({wr_addr[n], wr_data[n]});
                else exp_wovf[n] = 1'b1;
            end
        end
    endtask

    task automatic step();
        if (rst) model_reset();
        else     model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            cmd[n] = '0; addr[n] = '0; data[n] = '0;
            rd_en[n] = 1'b0; rd_addr[n] = '0;
            wr_en[n] = 1'b0; wr_addr[n] = '0; wr_data[n] = '0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({snp_cmd, snp_addr, snp_data, snp_src} !== '0) begin
            errors++;
            $display("FAIL reset_snp: got %h/%0d, expected 0", {snp_cmd, snp_addr, snp_data}, snp_src);
        end
        vectors++;
        if ({rd_data[0], rd_data[1], bus_ovf, wbuf_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_rd_ovf: got rd %h/%h ovf %b/%b, expected all 0",
                     rd_data[0], rd_data[1], bus_ovf, wbuf_ovf);
        end
    endtask

    task automatic test_single_broadcast();
        pulse_reset();
        cmd[0] = 2'b01; addr[0] = 11'h024; data[0] = 8'h00;
        step();
        idle();
        vectors++;
        if ({snp_cmd, snp_addr, snp_src} !== {2'b01, 11'h024, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: got cmd=%0d addr=%h src=%0d, expected cmd=1 addr=024 src=0",
                     snp_cmd, snp_addr, snp_src);
        end
        step();
        vectors++;
        if ({snp_cmd, snp_addr, snp_data, snp_src} !== '0) begin
            errors++;
            $display("FAIL single_pulse_end: got cmd=%0d addr=%h data=%h src=%0d, expected idle",
                     snp_cmd, snp_addr, snp_data, snp_src);
        end
    endtask

    task automatic test_contest();
        pulse_reset();
        cmd[0] = 2'b10; addr[0] = 11'h100; data[0] = 8'hAA;
        cmd[1] = 2'b10; addr[1] = 11'h200; data[1] = 8'h55;
        step();
        idle();
        vectors++;
        if ({snp_cmd, snp_data, snp_src} !== {2'b10, 8'hAA, 1'b0}) begin
            errors++;
            $display("FAIL contest_first: got cmd=%0d data=%h src=%0d, expected cmd=2 data=AA src=0",
                     snp_cmd, snp_data, snp_src);
        end
        step();
        vectors++;
        if ({snp_cmd, snp_addr, snp_data, snp_src} !== {2'b10, 11'h200, 8'h55, 1'b1}) begin
            errors++;
            $display("FAIL contest_second: got cmd=%0d addr=%h data=%h src=%0d, expected cmd=2 addr=200 data=55 src=1",
                     snp_cmd, snp_addr, snp_data, snp_src);
        end
        for (int i = 0; i < 3; i++) begin
            cmd[0] = 2'b11; addr[0] = AB'(i); data[0] = DB'(8'h10 + i);
            cmd[1] = 2'b01; addr[1] = AB'(8 + i); data[1] = DB'(8'h20 + i);
            step();
            vectors++;
            if ({snp_cmd, snp_addr, snp_data} !== exp_snp || snp_src !== exp_src) begin
                errors++;
                $display("FAIL contest_repeat cyc %0d: got %h/%0d, expected %h/%0d",
                         i, {snp_cmd, snp_addr, snp_data}, snp_src, exp_snp, exp_src);
            end
        end
        idle();
    endtask

    task automatic test_bus_ovf();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            cmd[0] = 2'b01; addr[0] = AB'(16 + i); data[0] = DB'(i);
            cmd[1] = 2'b10; addr[1] = AB'(32 + i); data[1] = DB'(8'h80 + i);
            step();
            vectors++;
            if ({snp_cmd, snp_addr, snp_data} !== exp_snp || snp_src !== exp_src) begin
                errors++;
                $display("FAIL ovf_stream_snp cyc %0d: got %h/%0d, expected %h/%0d",
                         i, {snp_cmd, snp_addr, snp_data}, snp_src, exp_snp, exp_src);
            end
        end
        idle();
        vectors++;
        if (bus_ovf !== 2'b10) begin
            errors++;
            $display("FAIL bus_ovf_set: got %b, expected 10", bus_ovf);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({snp_cmd, snp_addr, snp_data} !== exp_snp || snp_src !== exp_src) begin
                errors++;
                $display("FAIL ovf_drain_snp cyc %0d: got %h/%0d, expected %h/%0d",
                         i, {snp_cmd, snp_addr, snp_data}, snp_src, exp_snp, exp_src);
            end
        end
        vectors++;
        if (bus_ovf !== 2'b10) begin
            errors++;
            $display("FAIL bus_ovf_sticky: got %b, expected 10", bus_ovf);
        end
    endtask

    task automatic test_forwarding();
        pulse_reset();
        wr_en[0] = 1'b1; wr_addr[0] = 6'h12; wr_data[0] = 8'h3C;
        rd_en[1] = 1'b1; rd_addr[1] = 6'h12;
        step();
        idle();
        vectors++;
        if (rd_data[1] !== 8'h00) begin
            errors++;
            $display("FAIL same_cycle_rd: got %h, expected 00", rd_data[1]);
        end
        rd_en[1] = 1'b1; rd_addr[1] = 6'h12;
        step();
        idle();
        vectors++;
        if (rd_data[1] !== 8'h3C) begin
            errors++;
            $display("FAIL cross_forward: got %h, expected 3C", rd_data[1]);
        end
        wr_en[0] = 1'b1; wr_addr[0] = 6'h21; wr_data[0] = 8'h5A;
        wr_en[1] = 1'b1; wr_addr[1] = 6'h21; wr_data[1] = 8'hA5;
        step();
        idle();
        rd_en[0] = 1'b1; rd_addr[0] = 6'h21;
        rd_en[1] = 1'b1; rd_addr[1] = 6'h21;
        step();
        idle();
        vectors++;
        if (rd_data[0] !== 8'h5A || rd_data[1] !== 8'hA5) begin
            errors++;
            $display("FAIL own_priority: got %h/%h, expected 5A/A5", rd_data[0], rd_data[1]);
        end
        for (int i = 0; i < 6; i++) step();
        rd_en[0] = 1'b1; rd_addr[0] = 6'h21;
        step();
        idle();
        vectors++;
        if (rd_data[0] !== exp_rd[0]) begin
            errors++;
            $display("FAIL drained_value: got %h, expected %h", rd_data[0], exp_rd[0]);
        end
    endtask

    task automatic test_wbuf_ovf();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en[0] = 1'b1; wr_addr[0] = MB'(i);      wr_data[0] = DB'($urandom);
            wr_en[1] = 1'b1; wr_addr[1] = MB'(32 + i); wr_data[1] = DB'($urandom);
            step();
            if (i == 6) begin
                vectors++;
                if (wbuf_ovf !== 2'b00) begin
                    errors++;
                    $display("FAIL wbuf_full_popping: got %b, expected 00", wbuf_ovf);
                end
            end
        end
        idle();
        vectors++;
        if (wbuf_ovf !== 2'b11) begin
            errors++;
            $display("FAIL wbuf_ovf_set: got %b, expected 11", wbuf_ovf);
        end
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 10; i++) begin
            rd_en[0] = 1'b1; rd_addr[0] = MB'(i);
            rd_en[1] = 1'b1; rd_addr[1] = MB'(32 + i);
            step();
            vectors++;
            if (rd_data[0] !== exp_rd[0] || rd_data[1] !== exp_rd[1]) begin
                errors++;
                $display("FAIL wbuf_array_readback %0d: got %h/%h, expected %h/%h",
                         i, rd_data[0], rd_data[1], exp_rd[0], exp_rd[1]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 2; n++) begin
                cmd[n]     = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                addr[n]    = AB'($urandom);
                data[n]    = DB'($urandom);
                rd_en[n]   = ($urandom_range(0, 2) == 0);
                rd_addr[n] = MB'($urandom_range(0, 7));
                wr_en[n]   = ($urandom_range(0, 1) == 0);
                wr_addr[n] = MB'($urandom_range(0, 7));
                wr_data[n] = DB'($urandom);
            end
            step();
            vectors++;
            if ({snp_cmd, snp_addr, snp_data} !== exp_snp || snp_src !== exp_src) begin
                errors++;
                $display("FAIL rand_snp cyc %0d: got %h/%0d, expected %h/%0d",
                         i, {snp_cmd, snp_addr, snp_data}, snp_src, exp_snp, exp_src);
            end
            vectors++;
            if (rd_data[0] !== exp_rd[0] || rd_data[1] !== exp_rd[1]) begin
                errors++;
                $display("FAIL rand_rd cyc %0d: got %h/%h, expected %h/%h",
                         i, rd_data[0], rd_data[1], exp_rd[0], exp_rd[1]);
            end
            vectors++;
            if (bus_ovf !== exp_bovf || wbuf_ovf !== exp_wovf) begin
                errors++;
                $display("FAIL rand_ovf cyc %0d: got %b/%b, expected %b/%b",
                         i, bus_ovf, wbuf_ovf, exp_bovf, exp_wovf);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            for (int n = 0; n < 2; n++) begin
                cmd[n]   = 2'($urandom_range(1, 3));
                addr[n]  = AB'($urandom);
                data[n]  = DB'($urandom);
                wr_en[n] = 1'b1;
                wr_addr[n] = MB'($urandom_range(0, 7));
                wr_data[n] = DB'($urandom_range(1, 255));
            end
            rd_en[0] = 1'b1; rd_addr[0] = MB'($urandom_range(0, 7));
            step();
        end
        vectors++;
        if (bus_ovf !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_busy: got bus_ovf %b, expected 11", bus_ovf);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        vectors++;
        if ({snp_cmd, snp_addr, snp_data, snp_src} !== '0 || {rd_data[0], rd_data[1]} !== '0) begin
            errors++;
            $display("FAIL mid_reset_out: got snp %h/%0d rd %h/%h, expected 0",
                     {snp_cmd, snp_addr, snp_data}, snp_src, rd_data[0], rd_data[1]);
        end
        vectors++;
        if ({bus_ovf, wbuf_ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset_ovf: got %b/%b, expected 00/00", bus_ovf, wbuf_ovf);
        end
        step();
        vectors++;
        if (snp_cmd !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_queue_flush: got cmd %0d, expected 0", snp_cmd);
        end
        for (int i = 0; i < 8; i++) begin
            rd_en[0] = 1'b1; rd_addr[0] = MB'(i);
            rd_en[1] = 1'b1; rd_addr[1] = MB'(7 - i);
            step();
            vectors++;
            if (rd_data[0] !== 8'h00 || rd_data[1] !== 8'h00) begin
                errors++;
                $display("FAIL mid_reset_mem %0d: got %h/%h, expected 00/00", i, rd_data[0], rd_data[1]);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_broadcast();
        test_contest();
        test_bus_ovf();
        test_forwarding();
        test_wbuf_ovf();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
